// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: adder geometry, latency and the
// Montgomery controller state encoding.
package rsa_pkg;

    // Default operand width of the RSA datapath.
    localparam int OP_W    = 512;

    // Adder operand width: operands are zero-extended to this width so that
    // the intermediate C + A + M sums never overflow.
    localparam int ADD_W   = 514;

    // Cycles from adder start to adder done.
    localparam int ADD_LAT = 4;

    // Montgomery controller states.
    typedef enum logic [2:0] {
        IDLE,
        ADD_A,
        WAIT_A,
        ADD_M,
        WAIT_M,
        SUB,
        WAIT_S,
        DONE
    } state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int bit_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder.sv
// 514-bit multi-cycle adder/subtractor. The sum is a multicycle path: the
// caller holds in_a, in_b, subtract and shift stable from start until done.
// result[ADD_W] is the carry out of the unshifted sum; for a subtraction it
// is 1 exactly when in_a >= in_b. With shift=1 the whole sum is shifted
// right by one bit, so the carry lands in result[ADD_W-1].
module adder
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic             shift,
    input  logic [ADD_W-1:0] in_a,
    input  logic [ADD_W-1:0] in_b,
    output logic [ADD_W:0]   result,
    output logic             done
);

    localparam int               LAT_W    = $clog2(ADD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT);

    logic [LAT_W-1:0] lat_cnt;
    logic [ADD_W:0]   sum;

    // Latency counter: loads on start while idle, done is its final count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!resetn) begin
            lat_cnt <= '0;
        end else if (lat_cnt == '0) begin
            if (start) begin
                lat_cnt <= LAT_W'(1);
            end
        end else if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
        end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    // Two's-complement add/subtract with optional right shift of the sum.
    always_comb begin
        sum    = {1'b0, in_a}
               + {1'b0, (subtract ? ~in_b : in_b)}
               + {{ADD_W{1'b0}}, subtract};
        result = shift ? {1'b0, sum[ADD_W:1]} : sum;
    end

    assign done = (lat_cnt == LAT_LAST);

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-N mod M. Every step is
// issued to one shared multi-cycle adder, including the skipped additions
// (driven with a zero operand), so the run time never depends on the data.
module montgomery_mult
    import rsa_pkg::*;
#(
    parameter int N = OP_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int               CNT_W  = bit_cnt_width(N);
    localparam logic [CNT_W-1:0] N_BITS = CNT_W'(N);
    localparam int               PAD_W  = ADD_W - N;

    state_t state;
    state_t state_nx;

    // Latched operands; b_sh walks B LSB-first, one bit per iteration.
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_sh;
    logic [N-1:0]     m_reg;

    // Accumulator: holds C between iterations and C1 between the two steps.
    logic [ADD_W-1:0] c_acc;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nx;
    logic             more_bits;

    logic             add_start;
    logic             add_sub;
    logic             add_shift;
    logic             add_done;
    logic [ADD_W-1:0] add_in_a;
    logic [ADD_W-1:0] add_in_b;
    logic [ADD_W:0]   add_result;
    logic [ADD_W-1:0] a_ext;
    logic [ADD_W-1:0] m_ext;

    assign a_ext      = {{PAD_W{1'b0}}, a_reg};
    assign m_ext      = {{PAD_W{1'b0}}, m_reg};
    assign bit_cnt_nx = bit_cnt + CNT_W'(1);
    assign more_bits  = (bit_cnt_nx < N_BITS);

    // State register; a start coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode, adder start strobe and the done pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can infer a latch.
        state_nx  = state;
        add_start = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ADD_A;
                end
            end
            ADD_A: begin
                add_start = 1'b1;
                state_nx  = WAIT_A;
            end
            WAIT_A: begin
                if (add_done) begin
                    state_nx = ADD_M;
                end
            end
            ADD_M: begin
                add_start = 1'b1;
                state_nx  = WAIT_M;
            end
            WAIT_M: begin
                if (add_done) begin
                    state_nx = more_bits ? ADD_A : SUB;
                end
            end
            SUB: begin
                add_start = 1'b1;
                state_nx  = WAIT_S;
            end
            WAIT_S: begin
                if (add_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Adder operand mux: controls stay stable from issue through done
    // because they decode from the issue state and its matching wait state.
    always_comb begin
        add_in_a  = c_acc;
        add_in_b  = '0;
        add_sub   = 1'b0;
        add_shift = 1'b0;
        case (state)
            ADD_A, WAIT_A: begin
                add_in_b = b_sh[0] ? a_ext : '0;
            end
            ADD_M, WAIT_M: begin
                add_in_b  = c_acc[0] ? m_ext : '0;
                add_shift = 1'b1;
            end
            SUB, WAIT_S: begin
                add_in_b = m_ext;
                add_sub  = 1'b1;
            end
            default: begin
                add_in_b = '0;
            end
        endcase
    end

    // Operand latches: loaded on an accepted start, B shifts once per iteration.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always reloaded on the accepted start
        // before anything reads them, so resetting them would add only fanout.
        if (state == IDLE && start) begin
            a_reg <= in_a;
            b_sh  <= in_b;
            m_reg <= in_m;
        end else if (state == WAIT_M && add_done) begin
            b_sh  <= b_sh >> 1;
        end
    end

    // Accumulator, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            c_acc   <= '0;
            bit_cnt <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        c_acc   <= '0;
                        bit_cnt <= '0;
                    end
                end
                WAIT_A: begin
                    if (add_done) begin
                        c_acc <= add_result[ADD_W-1:0];
                    end
                end
                WAIT_M: begin
                    if (add_done) begin
                        c_acc   <= add_result[ADD_W-1:0];
                        bit_cnt <= bit_cnt_nx;
                    end
                end
                WAIT_S: begin
                    // Carry set means C >= M, so the difference is the reduced value.
                    if (add_done) begin
                        result <= add_result[ADD_W] ? add_result[N-1:0] : c_acc[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    adder u_adder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start),
        .subtract (add_sub),
        .shift    (add_shift),
        .in_a     (add_in_a),
        .in_b     (add_in_b),
        .result   (add_result),
        .done     (add_done)
    );

endmodule
